// File: rtl/seq_divider_if.sv
// Handshake and data bundle for the sequential divider: requests flow master -> slave,
// status and results flow back.
interface seq_divider_if #(
    parameter int N_WIDTH = 10,
    parameter int D_WIDTH = 8
);
    logic               start;
    logic               is_signed;
    logic [N_WIDTH-1:0] numerator;
    logic [D_WIDTH-1:0] denominator;
    logic               busy;
    logic               done;
    logic [N_WIDTH-1:0] quotient;
    logic [D_WIDTH-1:0] remain;
    logic               div_by_zero;
    logic               overflow;

    modport master (
        output start, is_signed, numerator, denominator,
        input  busy, done, quotient, remain, div_by_zero, overflow
    );

    modport slave (
        input  start, is_signed, numerator, denominator,
        output busy, done, quotient, remain, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock on operand magnitudes,
// followed by a sign-fix cycle. Handles runtime signed mode, zero divide and min/-1.
module seq_divider #(
    parameter int N_WIDTH = 10,
    parameter int D_WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam int CW = (N_WIDTH > 2) ? $clog2(N_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    function automatic logic [N_WIDTH-1:0] neg_n(input logic [N_WIDTH-1:0] v);
        return ~v + N_WIDTH'(1);
    endfunction

    function automatic logic [D_WIDTH-1:0] neg_d(input logic [D_WIDTH-1:0] v);
        return ~v + D_WIDTH'(1);
    endfunction

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_WIDTH-1:0] quo_q, quo_d;
    logic [D_WIDTH-1:0] den_q, den_d;
    logic [D_WIDTH-1:0] rem_q, rem_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               ovfc_q, ovfc_d;
    logic [N_WIDTH-1:0] quotient_q, quotient_d;
    logic [D_WIDTH-1:0] remain_q, remain_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;

    logic               n_neg, d_neg, is_min_n, is_m1_d;
    logic [N_WIDTH-1:0] n_mag;
    logic [D_WIDTH-1:0] d_mag;
    logic [D_WIDTH:0]   trial, diff;

    assign n_neg    = bus.is_signed & bus.numerator[N_WIDTH-1];
    assign d_neg    = bus.is_signed & bus.denominator[D_WIDTH-1];
    assign n_mag    = n_neg ? neg_n(bus.numerator) : bus.numerator;
    assign d_mag    = d_neg ? neg_d(bus.denominator) : bus.denominator;
    assign is_min_n = (bus.numerator == {1'b1, {(N_WIDTH-1){1'b0}}});
    assign is_m1_d  = (bus.denominator == {D_WIDTH{1'b1}});

    // Shift the next numerator bit into the partial remainder; a negative difference means restore.
    assign trial = {rem_q, quo_q[N_WIDTH-1]};
    assign diff  = trial - {1'b0, den_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        den_d      = den_q;
        rem_d      = rem_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        ovfc_d     = ovfc_q;
        quotient_d = quotient_q;
        remain_d   = remain_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b0;
                    quo_d  = n_mag;
                    den_d  = d_mag;
                    rem_d  = '0;
                    negq_d = n_neg ^ d_neg;
                    negr_d = n_neg;
                    ovfc_d = bus.is_signed & is_min_n & is_m1_d;
                    cnt_d  = CW'(N_WIDTH - 1);
                    if (bus.denominator == '0) begin
                        state_d    = DONE;
                        quotient_d = '1;
                        remain_d   = '0;
                        dbz_d      = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (diff[D_WIDTH]) begin
                    rem_d = trial[D_WIDTH-1:0];
                    quo_d = {quo_q[N_WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = diff[D_WIDTH-1:0];
                    quo_d = {quo_q[N_WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d = negq_q ? neg_n(quo_q) : quo_q;
                remain_d   = negr_q ? neg_d(rem_q) : rem_q;
                ovf_d      = ovfc_q;
                state_d    = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            den_q      <= '0;
            rem_q      <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            ovfc_q     <= 1'b0;
            quotient_q <= '0;
            remain_q   <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            den_q      <= den_d;
            rem_q      <= rem_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            ovfc_q     <= ovfc_d;
            quotient_q <= quotient_d;
            remain_q   <= remain_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.busy        = (state_q == CALC) || (state_q == FIX);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remain      = remain_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vector table, multi-cycle corner sequences and
// randomized operations against an integer-arithmetic reference.
module tb_seq_divider;
    localparam int N = 10;
    localparam int D = 8;
    localparam int LAT = N + 2;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.N_WIDTH(N), .D_WIDTH(D)) bus ();

    seq_divider #(.N_WIDTH(N), .D_WIDTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         sg;
        logic [N-1:0] n;
        logic [D-1:0] d;
        logic [N-1:0] q;
        logic [D-1:0] r;
        logic         dz;
        logic         ov;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Reference: plain integer division (truncates toward zero, remainder follows dividend).
    function automatic void model(input logic sg, input logic [N-1:0] n, input logic [D-1:0] d,
                                  output logic [N-1:0] q, output logic [D-1:0] r,
                                  output logic dz, output logic ov);
        int ni, di, qi, ri;
        dz = 1'b0;
        ov = 1'b0;
        if (d == '0) begin
            q  = '1;
            r  = '0;
            dz = 1'b1;
        end else begin
            if (sg) begin
                ni = $signed(n);
                di = $signed(d);
            end else begin
                ni = int'(n);
                di = int'(d);
            end
            if (sg && ni == -(1 << (N - 1)) && di == -1) begin
                q  = n;
                r  = '0;
                ov = 1'b1;
            end else begin
                qi = ni / di;
                ri = ni % di;
                q  = qi[N-1:0];
                r  = ri[D-1:0];
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge of the cycle where done is seen.
    task automatic run_op(input logic sg, input logic [N-1:0] n, input logic [D-1:0] d,
                          output int lat, output int bcnt);
        bus.start       = 1'b1;
        bus.is_signed   = sg;
        bus.numerator   = n;
        bus.denominator = d;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.is_signed   = ~sg;
        bus.numerator   = N'($urandom);
        bus.denominator = D'($urandom);
        lat  = -1;
        bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) bcnt++;
        end
    endtask

    initial begin
        int lat, bcnt, first_done, n_done;
        logic [N-1:0] eq;
        logic [D-1:0] er;
        logic edz, eov, sg;
        logic [N-1:0] rn;
        logic [D-1:0] rd;

        vt[0]  = '{1'b0, 10'd1000,  8'd7,    10'd142,   8'd6,    1'b0, 1'b0};
        vt[1]  = '{1'b0, 10'd500,   8'd0,    10'd1023,  8'd0,    1'b1, 1'b0};
        vt[2]  = '{1'b1, 10'h39C,   8'd7,    10'h3F2,   8'hFE,   1'b0, 1'b0};
        vt[3]  = '{1'b1, 10'd100,   8'hF9,   10'h3F2,   8'h02,   1'b0, 1'b0};
        vt[4]  = '{1'b1, 10'h200,   8'hFF,   10'h200,   8'h00,   1'b0, 1'b1};
        vt[5]  = '{1'b0, 10'd9,     8'd3,    10'd3,     8'd0,    1'b0, 1'b0};
        vt[6]  = '{1'b0, 10'd255,   8'd16,   10'd15,    8'd15,   1'b0, 1'b0};
        vt[7]  = '{1'b0, 10'd1023,  8'd1,    10'd1023,  8'd0,    1'b0, 1'b0};
        vt[8]  = '{1'b0, 10'd1023,  8'd255,  10'd4,     8'd3,    1'b0, 1'b0};
        vt[9]  = '{1'b1, 10'h200,   8'h80,   10'd4,     8'd0,    1'b0, 1'b0};
        vt[10] = '{1'b1, 10'd5,     8'h80,   10'd0,     8'd5,    1'b0, 1'b0};
        vt[11] = '{1'b1, 10'h3F9,   8'd2,    10'h3FD,   8'hFF,   1'b0, 1'b0};
        vt[12] = '{1'b0, 10'h200,   8'hFF,   10'd2,     8'd2,    1'b0, 1'b0};
        vt[13] = '{1'b1, 10'h200,   8'd0,    10'h3FF,   8'd0,    1'b1, 1'b0};

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.is_signed   = 1'b0;
        bus.numerator   = '0;
        bus.denominator = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_q", bus.quotient, 0);
        chk("reset_r", bus.remain, 0);
        chk("reset_dz", bus.div_by_zero, 0);
        chk("reset_ov", bus.overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_op(vt[i].sg, vt[i].n, vt[i].d, lat, bcnt);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].dz ? 1 : LAT);
            chk($sformatf("vec%0d_busy", i), bcnt, vt[i].dz ? 0 : LAT - 1);
            chk($sformatf("vec%0d_q", i), bus.quotient, vt[i].q);
            chk($sformatf("vec%0d_r", i), bus.remain, vt[i].r);
            chk($sformatf("vec%0d_dz", i), bus.div_by_zero, vt[i].dz);
            chk($sformatf("vec%0d_ov", i), bus.overflow, vt[i].ov);
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d_hold_q", i), bus.quotient, vt[i].q);
            chk($sformatf("vec%0d_done_low", i), bus.done, 0);
        end

        // Start pulsed mid-calculation is ignored.
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.numerator = 10'd1000; bus.denominator = 8'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        first_done = -1;
        n_done = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 4) begin
                bus.start = 1'b1; bus.numerator = 10'd300; bus.denominator = 8'd3;
            end
            if (k == 5) bus.start = 1'b0;
            if (bus.done) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = k;
                    chk("midstart_q", bus.quotient, 142);
                    chk("midstart_r", bus.remain, 6);
                end
            end
        end
        chk("midstart_lat", first_done, LAT);
        chk("midstart_ndone", n_done, 1);

        // Reset mid-operation aborts with no done.
        bus.start = 1'b1; bus.numerator = 10'd1000; bus.denominator = 8'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_q", bus.quotient, 0);
        chk("abort_r", bus.remain, 0);
        rst = 1'b0;
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done || bus.busy) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        run_op(1'b0, 10'd255, 8'd16, lat, bcnt);
        chk("after_abort_lat", lat, LAT);
        chk("after_abort_q", bus.quotient, 15);
        chk("after_abort_r", bus.remain, 15);

        // Start accepted during the DONE cycle.
        @(negedge clk);
        run_op(1'b0, 10'd1000, 8'd7, lat, bcnt);
        chk("b2b_first_q", bus.quotient, 142);
        run_op(1'b0, 10'd77, 8'd10, lat, bcnt);
        chk("b2b_lat", lat, LAT);
        chk("b2b_q", bus.quotient, 7);
        chk("b2b_r", bus.remain, 7);

        // Randomized operations against the reference.
        for (int i = 0; i < 200; i++) begin
            sg = 1'($urandom);
            rn = N'($urandom);
            rd = ($urandom_range(0, 15) == 0) ? '0 : D'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                sg = 1'b1; rn = {1'b1, {(N-1){1'b0}}}; rd = '1;
            end
            model(sg, rn, rd, eq, er, edz, eov);
            run_op(sg, rn, rd, lat, bcnt);
            chk($sformatf("rnd%0d_lat", i), lat, edz ? 1 : LAT);
            chk($sformatf("rnd%0d_q", i), bus.quotient, eq);
            chk($sformatf("rnd%0d_r", i), bus.remain, er);
            chk($sformatf("rnd%0d_flags", i), {bus.div_by_zero, bus.overflow}, {edz, eov});
            if (i % 3 == 0) @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
